// File: rtl/mem_addr_pkg.sv
// Shared definitions for the memory address unit: select codes, FSM states, default widths.
package mem_addr_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_ALT  = 2'b01;
    localparam logic [1:0] SEL_BUS  = 2'b10;
    localparam logic [1:0] SEL_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mem_addr_unit_ar_next_mux.sv
// Combinational next-AR selection from the select code, with illegal-code detect.
// A non-hold select wins over the increment term; selects only count while load_en is high.
import mem_addr_pkg::*;

module ar_next_mux #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] bus,
    input  logic [ADDR_W-1:0] alt,
    input  logic [ADDR_W-1:0] ar,
    input  logic              load_en,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] ar_next,
    output logic              ill
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        ar_next = ar;
        ill     = 1'b0;
        if (load_en && sel != SEL_HOLD) begin
            case (sel)
                SEL_ALT: ar_next = alt;
                SEL_BUS: ar_next = bus;
                SEL_ILL: begin
                    ar_next = bus;
                    ill     = 1'b1;
                end
                default: ar_next = ar;
            endcase
        end else if (inc_en) begin
            ar_next = ar + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/mem_addr_unit.sv
// Address register plus single-access sequencer toward a fixed-latency synchronous RAM.
// Define MEM_ADDR_AUTOINC_EN to post-increment AR on every completed access.
import mem_addr_pkg::*;

module mem_addr_unit #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        sel_in,
    input  logic [ADDR_W-1:0] bus_in,
    input  logic [ADDR_W-1:0] alt_in,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              req_ready,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    output logic              done,
    output logic [ADDR_W-1:0] ar_out,
    output logic              sel_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = 2;
    // Last WAIT count before RESP; WAIT is skipped entirely when RD_LAT is 1.
    localparam int WAIT_LAST_I = (RD_LAT > 1) ? RD_LAT - 2 : 0;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LAST_I);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ar_q, ar_nxt;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rdata_valid_q;
    logic              sel_err_q;
    logic              ill;
    logic              inc_en;

    assign done = (state == ST_ISSUE && we_q) || rdata_valid_q;

`ifdef MEM_ADDR_AUTOINC_EN
    assign inc_en = done;
`else
    assign inc_en = 1'b0;
`endif

    ar_next_mux #(.ADDR_W(ADDR_W)) u_ar_next_mux (
        .sel     (sel_in),
        .bus     (bus_in),
        .alt     (alt_in),
        .ar      (ar_q),
        .load_en (state == ST_IDLE),
        .inc_en  (inc_en),
        .ar_next (ar_nxt),
        .ill     (ill)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (we_q)             state_nxt = ST_IDLE;
                else if (RD_LAT == 1) state_nxt = ST_RESP;
                else                  state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (cnt_q == WAIT_LAST) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ar_q          <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            state         <= state_nxt;
            ar_q          <= ar_nxt;
            sel_err_q     <= ill;
            rdata_valid_q <= (state == ST_RESP);
            if (state == ST_IDLE && req_valid) begin
                we_q    <= req_we;
                wdata_q <= wdata_in;
            end
            if (state == ST_WAIT) cnt_q <= cnt_q + CNT_W'(1);
            else                  cnt_q <= '0;
            if (state == ST_RESP) rdata_q <= mem_rdata;
        end
    end

    assign req_ready   = (state == ST_IDLE);
    assign rdata_out   = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign ar_out      = ar_q;
    assign sel_err     = sel_err_q;
    assign mem_en      = (state == ST_ISSUE);
    assign mem_we      = (state == ST_ISSUE) && we_q;
    assign mem_addr    = ar_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_addr_unit.sv
// Directed bench for mem_addr_unit (RD_LAT=2) with a read-data scoreboard and a small RAM model.
module tb_mem_addr_unit;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RL = 2;
`ifdef MEM_ADDR_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    sel_in;
    logic [AW-1:0] bus_in, alt_in;
    logic          req_valid, req_we;
    logic [DW-1:0] wdata_in;
    logic          req_ready, rdata_valid, done, sel_err;
    logic          mem_en, mem_we;
    logic [DW-1:0] rdata_out, mem_wdata, mem_rdata;
    logic [AW-1:0] ar_out, mem_addr;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe0, rd_pipe1;
    logic [DW-1:0] sb [$];

    int n_checks = 0;
    int n_err    = 0;

    mem_addr_unit #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_in      (sel_in),
        .bus_in      (bus_in),
        .alt_in      (alt_in),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .wdata_in    (wdata_in),
        .req_ready   (req_ready),
        .rdata_out   (rdata_out),
        .rdata_valid (rdata_valid),
        .done        (done),
        .ar_out      (ar_out),
        .sel_err     (sel_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: data appears RL cycles after the enable cycle.
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        rd_pipe0 <= ram[mem_addr];
        rd_pipe1 <= rd_pipe0;
    end
    assign mem_rdata = rd_pipe1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && rdata_valid) begin
            if (sb.size() == 0) chk("rdata_unexpected_qsize", 32'(sb.size()), 32'd1);
            else                chk("rdata_sb", 32'(rdata_out), 32'(sb.pop_front()));
        end
    end

    initial begin
        rst_n = 1'b0; sel_in = 2'b00; bus_in = '0; alt_in = '0;
        req_valid = 1'b0; req_we = 1'b0; wdata_in = '0;
        #3;
        chk("rst_ar", 32'(ar_out), 32'h0);
        chk("rst_pulses", {29'd0, done, rdata_valid, sel_err}, 32'h0);
        chk("rst_mem", {31'd0, mem_en}, 32'h0);
        chk("rst_rdata", 32'(rdata_out), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        cyc();
        chk("rel_ready", {31'd0, req_ready}, 32'h1);

        // Select decode: bus, alt, hold
        sel_in = 2'b10; bus_in = 16'h0040; cyc();
        chk("ld_bus", 32'(ar_out), 32'h0040);
        sel_in = 2'b01; alt_in = 16'h1234; cyc();
        chk("ld_alt", 32'(ar_out), 32'h1234);
        sel_in = 2'b00; bus_in = 16'hFFFF; alt_in = 16'hFFFF; cyc();
        chk("hold", 32'(ar_out), 32'h1234);

        // Illegal code: bus dominates, single sel_err pulse
        sel_in = 2'b11; bus_in = 16'h00AA; cyc();
        chk("ill_ar", 32'(ar_out), 32'h00AA);
        chk("ill_err", {31'd0, sel_err}, 32'h1);
        sel_in = 2'b00; cyc();
        chk("ill_err_clr", {31'd0, sel_err}, 32'h0);

        // Load and write in the same cycle
        sel_in = 2'b10; bus_in = 16'h0005; req_valid = 1'b1; req_we = 1'b1; wdata_in = 16'hBEEF;
        cyc();
        sel_in = 2'b00; req_valid = 1'b0;
        chk("wr_mem_en", {30'd0, mem_en, mem_we}, 32'h3);
        chk("wr_addr", 32'(mem_addr), 32'h0005);
        chk("wr_wdata", 32'(mem_wdata), 32'hBEEF);
        chk("wr_done", {30'd0, done, req_ready}, 32'h2);
        cyc();
        chk("wr_after", {29'd0, done, mem_en, req_ready}, 32'h1);
        chk("wr_ar", 32'(ar_out), AUTOINC ? 32'h0006 : 32'h0005);

        // Store 0x7777 at 0x0300 for the read test
        sel_in = 2'b10; bus_in = 16'h0300; req_valid = 1'b1; req_we = 1'b1; wdata_in = 16'h7777;
        cyc();
        req_valid = 1'b0; sel_in = 2'b00;
        cyc();

        // Read with busy-time requests and selects that must be ignored
        sel_in = 2'b10; bus_in = 16'h0300; req_valid = 1'b1; req_we = 1'b0; wdata_in = 16'h0000;
        cyc();
        sb.push_back(16'h7777);
        bus_in = 16'h0999;
        chk("rd_issue", {29'd0, mem_en, mem_we, req_ready}, 32'h4);
        chk("rd_addr", 32'(mem_addr), 32'h0300);
        cyc();
        chk("rd_wait", {29'd0, mem_en, rdata_valid, req_ready}, 32'h0);
        chk("rd_busy_ar", 32'(ar_out), 32'h0300);
        cyc();
        chk("rd_resp", {30'd0, rdata_valid, done}, 32'h0);
        req_valid = 1'b0; sel_in = 2'b00;
        cyc();
        chk("rd_valid", {30'd0, rdata_valid, done}, 32'h3);
        chk("rd_data", 32'(rdata_out), 32'h7777);
        chk("rd_ar_busy_sel", 32'(ar_out), 32'h0300);
        cyc();
        chk("rd_after", {29'd0, rdata_valid, done, mem_en}, 32'h0);
        chk("rd_hold_data", 32'(rdata_out), 32'h7777);
        chk("rd_after_ar", 32'(ar_out), AUTOINC ? 32'h0301 : 32'h0300);

        // Read back the earlier write; select in the done cycle beats the increment
        sel_in = 2'b10; bus_in = 16'h0005; req_valid = 1'b1; req_we = 1'b0;
        cyc();
        sb.push_back(16'hBEEF);
        req_valid = 1'b0; sel_in = 2'b00;
        for (int i = 0; i < 10 && !rdata_valid; i++) cyc();
        chk("rd2_valid_timeout", {31'd0, rdata_valid}, 32'h1);
        sel_in = 2'b01; alt_in = 16'h2222;
        cyc();
        sel_in = 2'b00;
        chk("rd2_alt_wins", 32'(ar_out), 32'h2222);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        // Wrap on write from 0xFFFF; select during ISSUE ignored
        sel_in = 2'b10; bus_in = 16'hFFFF; cyc();
        chk("ld_ffff", 32'(ar_out), 32'hFFFF);
        sel_in = 2'b00; req_valid = 1'b1; req_we = 1'b1; wdata_in = 16'h1111;
        cyc();
        req_valid = 1'b0; sel_in = 2'b01; alt_in = 16'h3333;
        chk("wrap_done", {31'd0, done}, 32'h1);
        cyc();
        chk("wrap_ar", 32'(ar_out), AUTOINC ? 32'h0000 : 32'hFFFF);
        cyc();
        sel_in = 2'b00;
        chk("wrap_alt", 32'(ar_out), 32'h3333);

        // Reset during WAIT abandons the read
        sel_in = 2'b10; bus_in = 16'h0300; req_valid = 1'b1; req_we = 1'b0;
        cyc();
        req_valid = 1'b0; sel_in = 2'b00;
        cyc();
        rst_n = 1'b0;
        #2;
        chk("mid_rst_ar", 32'(ar_out), 32'h0);
        chk("mid_rst_out", {28'd0, mem_en, done, rdata_valid, req_ready}, 32'h1);
        @(negedge clk); rst_n = 1'b1;
        cyc();
        chk("mid_rel_ready", {31'd0, req_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("mid_no_pulse", {30'd0, done, rdata_valid}, 32'h0);
        end
        chk("mid_ar", 32'(ar_out), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_addr_unit.md
Name: mem_addr_unit

Overview:
Consumer end of the 2-bit address-select code produced by the core's select generator: decodes the select, maintains the data-memory address register (AR), and sequences single read/write accesses to the core's data RAM. Sits between the core control unit and data memory in each processing core of the multicore matrix multiplier. Request/response handshake toward the control unit; fixed-latency synchronous RAM port toward memory.

Parameters:
ADDR_W, 16, width of AR and memory address
DATA_W, 16, memory word width
RD_LAT, 1, RAM read latency in cycles (1..4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sel_in  in  2  address select code: bit1 = bus transfer, bit0 = alternate source
bus_in  in  ADDR_W  address from data bus (bus-transfer source)
alt_in  in  ADDR_W  address from secondary mux
req_valid  in  1  access request
req_we  in  1  1 = write, 0 = read; sampled with req_valid
wdata_in  in  DATA_W  write data; sampled with req_valid
req_ready  out  1  unit idle and able to accept a request
rdata_out  out  DATA_W  read result, held until next read completes
rdata_valid  out  1  one-cycle pulse when rdata_out updates
done  out  1  one-cycle pulse on completion of any access
ar_out  out  ADDR_W  current AR value
sel_err  out  1  one-cycle pulse when illegal code 2'b11 is decoded
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address (= AR)
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after mem_en

Behaviour:
- Reset (async assert, sync release): AR=0, state IDLE, rdata_out=0, all pulses and mem_* = 0, req_ready=1 after release.
- Select decode (IDLE only; ignored in all other states):
  - 00: hold AR.
  - 01: AR <= alt_in.
  - 10: AR <= bus_in.
  - 11: illegal (generator never emits it). AR <= bus_in (bus dominates); sel_err pulses the next cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch req_we and wdata_in; go to ISSUE.
  - If a load code and req_valid arrive in the same cycle, the access uses the newly loaded AR (ISSUE reads the registered AR).
- ISSUE: mem_en=1, mem_we=latched we, mem_addr=AR, mem_wdata=latched data.
  - Write: done pulses the same cycle; go to IDLE.
  - Read: go to WAIT.
- WAIT: count RD_LAT-1 cycles (0 cycles when RD_LAT=1); then go to RESP.
- RESP: rdata_out <= mem_rdata; rdata_valid and done pulse the following cycle; go to IDLE.
- Latency:
  - Write: accepted at edge N, done at N+1.
  - Read: rdata_valid at N+1+RD_LAT.
- mem_en is high exactly one cycle per access. req_ready is low in ISSUE/WAIT/RESP; req_valid in those states is not accepted.
- AR wraps modulo 2^ADDR_W.
- rst_n asserted mid-access: access abandoned, no done pulse, all state returns to reset values immediately.

Optional Feature:
MEM_ADDR_AUTOINC_EN:
- Defined: on the cycle done pulses, AR <= AR+1 (wraps from all-ones to 0). A simultaneous non-00 select in IDLE overrides the increment.
- Undefined: AR changes only via select codes.

Decomposition:
- Shared package mem_addr_pkg holds:
  - select code constants SEL_HOLD=2'b00, SEL_ALT=2'b01, SEL_BUS=2'b10, SEL_ILL=2'b11;
  - FSM state enum;
  - default ADDR_W/DATA_W.
- One natural sub-module, ar_next_mux: combinational next-AR selection from sel_in, bus_in, alt_in, and the increment term, plus illegal-code detect. FSM and latency counter stay in the top.

Test Plan:
- Reset mid-read (RD_LAT=3, rst_n low during WAIT) -> AR=0, req_ready=1 after release, no rdata_valid/done pulse.
- sel_in=10, bus_in=0x0040, then sel_in=01, alt_in=0x1234 -> ar_out 0x0040 then 0x1234; sel_in=00 holds 0x1234.
- sel_in=11, bus_in=0x00AA -> ar_out=0x00AA, sel_err single pulse.
- Same cycle sel_in=10, bus_in=0x0005, req_valid=1, req_we=1, wdata=0xBEEF -> next cycle mem_en=1, mem_we=1, mem_addr=0x0005, mem_wdata=0xBEEF, done pulse.
- Read with RD_LAT=2, RAM holding 0x7777 at AR -> rdata_valid 3 cycles after accept, rdata_out=0x7777; req_valid during busy ignored; sel_in=10 during busy leaves AR unchanged.
- MEM_ADDR_AUTOINC_EN defined, AR=0xFFFF, one write -> AR=0x0000 after done; same with sel_in=01 in the following IDLE cycle -> alt_in wins.
